// File: rtl/interfaz_alu_uart_pkg.sv
// Shared definitions for the UART-to-ALU front end: default widths, watchdog length
// and the sequencing state encoding.
package interfaz_alu_uart_pkg;

    localparam int CANT_BITS_DATO_DEF   = 8;
    localparam int CANT_BUS_ENTRADA_DEF = 4;
    localparam int CANT_BUS_SALIDA_DEF  = 4;
    localparam int CANT_BITS_OPCODE_DEF = 4;
    localparam int TIMEOUT_TX_DEF       = 1024;

    typedef enum logic [2:0] {
        ESPERA_OP1    = 3'd0,
        ESPERA_OP2    = 3'd1,
        ESPERA_OPCODE = 3'd2,
        CALCULO       = 3'd3,
        ESPERA_TX     = 3'd4
    } estado_t;

endpackage

// File: rtl/interfaz_alu_uart_if.sv
// Bundle of UART rx/tx handshakes and ALU operand/result lines.
// The master side is the UART/ALU environment; the slave side is interfaz_alu_uart.
interface interfaz_alu_uart_if
    import interfaz_alu_uart_pkg::*;
#(
    parameter int CANT_BITS_DATO   = CANT_BITS_DATO_DEF,
    parameter int CANT_BUS_ENTRADA = CANT_BUS_ENTRADA_DEF,
    parameter int CANT_BUS_SALIDA  = CANT_BUS_SALIDA_DEF,
    parameter int CANT_BITS_OPCODE = CANT_BITS_OPCODE_DEF
) ();

    logic                        rx_done;
    logic [CANT_BITS_DATO-1:0]   data_rx;
    logic                        tx_done;
    logic [CANT_BUS_SALIDA-1:0]  resultado_alu;
    logic [CANT_BUS_ENTRADA-1:0] operando_1;
    logic [CANT_BUS_ENTRADA-1:0] operando_2;
    logic [CANT_BITS_OPCODE-1:0] opcode;
    logic                        tx_start;
    logic [CANT_BITS_DATO-1:0]   data_tx;
    logic                        error;

    modport master (
        output rx_done, data_rx, tx_done, resultado_alu,
        input  operando_1, operando_2, opcode, tx_start, data_tx, error
    );

    modport slave (
        input  rx_done, data_rx, tx_done, resultado_alu,
        output operando_1, operando_2, opcode, tx_start, data_tx, error
    );

endinterface

// File: rtl/interfaz_alu_uart_contador_timeout.sv
// Transmit watchdog counter: counts while enabled, flags the terminal count
// TIMEOUT_TX-1; clear has priority over enable.
module interfaz_alu_uart_contador_timeout
    import interfaz_alu_uart_pkg::*;
#(
    parameter int TIMEOUT_TX = TIMEOUT_TX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic fin
);

    localparam int              ANCHO    = (TIMEOUT_TX > 1) ? $clog2(TIMEOUT_TX) : 1;
    localparam logic [ANCHO-1:0] TERMINAL = ANCHO'(TIMEOUT_TX - 1);

    logic [ANCHO-1:0] cuenta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta <= '0;
        end else if (clear) begin
            cuenta <= '0;
        end else if (enable) begin
            cuenta <= cuenta + 1'b1;
        end
    end

    // Not gated by enable so the FSM can use it without a combinational loop.
    assign fin = (cuenta == TERMINAL);

endmodule

// File: rtl/interfaz_alu_uart.sv
// Collects operand 1, operand 2 and opcode from three UART bytes, presents them to a
// combinational ALU and sends the result back through the UART transmitter.
module interfaz_alu_uart
    import interfaz_alu_uart_pkg::*;
#(
    parameter int CANT_BITS_DATO   = CANT_BITS_DATO_DEF,
    parameter int CANT_BUS_ENTRADA = CANT_BUS_ENTRADA_DEF,
    parameter int CANT_BUS_SALIDA  = CANT_BUS_SALIDA_DEF,
    parameter int CANT_BITS_OPCODE = CANT_BITS_OPCODE_DEF,
    parameter int TIMEOUT_TX       = TIMEOUT_TX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    interfaz_alu_uart_if.slave bus
);

    estado_t estado, estado_next;

    logic [CANT_BUS_ENTRADA-1:0] operando_1_q, operando_1_next;
    logic [CANT_BUS_ENTRADA-1:0] operando_2_q, operando_2_next;
    logic [CANT_BITS_OPCODE-1:0] opcode_q, opcode_next;
    logic [CANT_BITS_DATO-1:0]   data_tx_q, data_tx_next;
    logic                        tx_start_q, tx_start_next;
    logic                        error_q, error_next;

    logic contador_clear, contador_enable, contador_fin;

    interfaz_alu_uart_contador_timeout #(
        .TIMEOUT_TX (TIMEOUT_TX)
    ) u_contador (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (contador_clear),
        .enable (contador_enable),
        .fin    (contador_fin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= ESPERA_OP1;
            operando_1_q <= '0;
            operando_2_q <= '0;
            opcode_q     <= '0;
            data_tx_q    <= '0;
            tx_start_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            estado       <= estado_next;
            operando_1_q <= operando_1_next;
            operando_2_q <= operando_2_next;
            opcode_q     <= opcode_next;
            data_tx_q    <= data_tx_next;
            tx_start_q   <= tx_start_next;
            error_q      <= error_next;
        end
    end

    // Received bytes are only honoured in the three capture states; anything else drops them.
    always_comb begin
        estado_next     = estado;
        operando_1_next = operando_1_q;
        operando_2_next = operando_2_q;
        opcode_next     = opcode_q;
        data_tx_next    = data_tx_q;
        tx_start_next   = 1'b0;
        error_next      = 1'b0;
        contador_enable = 1'b0;
        contador_clear  = 1'b1;
        case (estado)
            ESPERA_OP1: begin
                if (bus.rx_done) begin
                    operando_1_next = bus.data_rx[CANT_BUS_ENTRADA-1:0];
                    estado_next     = ESPERA_OP2;
                end
            end
            ESPERA_OP2: begin
                if (bus.rx_done) begin
                    operando_2_next = bus.data_rx[CANT_BUS_ENTRADA-1:0];
                    estado_next     = ESPERA_OPCODE;
                end
            end
            ESPERA_OPCODE: begin
                if (bus.rx_done) begin
                    opcode_next = bus.data_rx[CANT_BITS_OPCODE-1:0];
                    estado_next = CALCULO;
                end
            end
            CALCULO: begin
                data_tx_next  = CANT_BITS_DATO'(bus.resultado_alu);
                tx_start_next = 1'b1;
                estado_next   = ESPERA_TX;
            end
            ESPERA_TX: begin
                contador_enable = 1'b1;
                contador_clear  = 1'b0;
                // A completion arriving on the expiry cycle takes precedence over the watchdog.
                if (bus.tx_done) begin
                    contador_clear = 1'b1;
                    estado_next    = ESPERA_OP1;
                end else if (contador_fin) begin
                    contador_clear = 1'b1;
                    error_next     = 1'b1;
                    estado_next    = ESPERA_OP1;
                end
            end
            default: begin
                estado_next = ESPERA_OP1;
            end
        endcase
    end

    assign bus.operando_1 = operando_1_q;
    assign bus.operando_2 = operando_2_q;
    assign bus.opcode     = opcode_q;
    assign bus.data_tx    = data_tx_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_interfaz_alu_uart.sv
// Scoreboard bench for interfaz_alu_uart: random byte triples, tx completions, watchdog
// expiries, collisions, dropped bytes and resets, with a small behavioural ALU attached.
module tb_interfaz_alu_uart;

    localparam int T_OUT  = 32;
    localparam int NORMAL = 0;
    localparam int VENCE  = 1;
    localparam int CHOQUE = 2;

    typedef struct {
        int data_tx;
        int op1;
        int op2;
        int opc;
        int ciclo;
    } esperado_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   mod_op1 = 0;
    int   mod_op2 = 0;
    int   mod_opc = 0;

    esperado_t exp_q[$];
    int        err_q[$];

    interfaz_alu_uart_if #(
        .CANT_BITS_DATO   (8),
        .CANT_BUS_ENTRADA (4),
        .CANT_BUS_SALIDA  (4),
        .CANT_BITS_OPCODE (4)
    ) bus ();

    interfaz_alu_uart #(
        .CANT_BITS_DATO   (8),
        .CANT_BUS_ENTRADA (4),
        .CANT_BUS_SALIDA  (4),
        .CANT_BITS_OPCODE (4),
        .TIMEOUT_TX       (T_OUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU on 4-bit values: 8 ADD, A SUB, C AND, D OR, E XOR, F NOR, 2 SRL.
    function automatic int alu_ref(input int a, input int b, input int opc);
        int r;
        case (opc)
            8:       r = a + b;
            10:      r = a - b;
            12:      r = a & b;
            13:      r = a | b;
            14:      r = a ^ b;
            15:      r = ~(a | b);
            2:       r = a >> b;
            default: r = 0;
        endcase
        return r & 15;
    endfunction

    always_comb bus.resultado_alu = 4'(alu_ref(int'(bus.operando_1), int'(bus.operando_2),
                                               int'(bus.opcode)));

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives one received byte for one cycle; returns the cycle it was presented in.
    task automatic applyStimulus(input int b, output int c);
        c           = cyc;
        bus.rx_done = 1'b1;
        bus.data_rx = 8'(b);
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    task automatic run_txn(input int b1, input int b2, input int b3, input int modo,
                           input bit junk_en, input int junk_byte);
        int k, s, done_c, end_c, junk_c;
        esperado_t e;
        if ($urandom_range(0, 3) == 0) begin
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
        end
        applyStimulus(b1, k);
        checkOutput("op1_capture", int'(bus.operando_1), b1 % 16);
        checkOutput("op2_hold", int'(bus.operando_2), mod_op2);
        applyStimulus(b2, k);
        applyStimulus(b3, k);
        mod_op1 = b1 % 16;
        mod_op2 = b2 % 16;
        mod_opc = b3 % 16;
        e.data_tx = alu_ref(mod_op1, mod_op2, mod_opc);
        e.op1     = mod_op1;
        e.op2     = mod_op2;
        e.opc     = mod_opc;
        e.ciclo   = k + 2;
        exp_q.push_back(e);
        s = k + 2;
        case (modo)
            VENCE: begin
                done_c = -1;
                end_c  = s + T_OUT - 1;
                err_q.push_back(s + T_OUT);
            end
            CHOQUE: begin
                done_c = s + T_OUT - 1;
                end_c  = done_c;
            end
            default: begin
                done_c = s + int'($urandom_range(0, T_OUT - 2));
                end_c  = done_c;
            end
        endcase
        junk_c = junk_en ? int'($urandom_range(k + 1, end_c)) : -1;
        while (cyc <= end_c) begin
            bus.rx_done = (cyc == junk_c);
            bus.data_rx = 8'(junk_byte);
            bus.tx_done = (cyc == done_c);
            @(negedge clk);
        end
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
        checkOutput("op1_hold_after", int'(bus.operando_1), mod_op1);
        checkOutput("opcode_hold_after", int'(bus.opcode), mod_opc);
    endtask

    // Monitor: every tx_start or error pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_start) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_tx_start", 1, 0);
                end else begin
                    esperado_t e;
                    e = exp_q.pop_front();
                    checkOutput("data_tx", int'(bus.data_tx), e.data_tx);
                    checkOutput("operando_1", int'(bus.operando_1), e.op1);
                    checkOutput("operando_2", int'(bus.operando_2), e.op2);
                    checkOutput("opcode", int'(bus.opcode), e.opc);
                    checkOutput("tx_start_cycle", cyc, e.ciclo);
                end
            end
            if (bus.error) begin
                if (err_q.size() == 0) checkOutput("unexpected_error", 1, 0);
                else checkOutput("error_cycle", cyc, err_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int ops[7] = '{8, 10, 12, 13, 14, 15, 2};
        int k;
        bus.rx_done = 1'b0;
        bus.data_rx = '0;
        bus.tx_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_operando_1", int'(bus.operando_1), 0);
        checkOutput("reset_operando_2", int'(bus.operando_2), 0);
        checkOutput("reset_opcode", int'(bus.opcode), 0);
        checkOutput("reset_data_tx", int'(bus.data_tx), 0);
        checkOutput("reset_tx_start", int'(bus.tx_start), 0);
        checkOutput("reset_error", int'(bus.error), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed transactions");
        run_txn('h0D, 'h05, 'h08, NORMAL, 1'b0, 0);
        run_txn('hF5, 'hA1, 'h0A, NORMAL, 1'b1, 'h07);
        run_txn('h03, 'h03, 'h0C, NORMAL, 1'b0, 0);
        run_txn('h19, 'h26, 'h0E, VENCE, 1'b0, 0);
        run_txn('h07, 'h02, 'h08, CHOQUE, 1'b0, 0);

        applyStimulus('h09, k);
        applyStimulus('h04, k);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_operando_1", int'(bus.operando_1), 0);
        checkOutput("midreset_operando_2", int'(bus.operando_2), 0);
        checkOutput("midreset_opcode", int'(bus.opcode), 0);
        checkOutput("midreset_data_tx", int'(bus.data_tx), 0);
        checkOutput("midreset_tx_start", int'(bus.tx_start), 0);
        checkOutput("midreset_error", int'(bus.error), 0);
        mod_op1 = 0;
        mod_op2 = 0;
        mod_opc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn('h05, 'h0D, 'h0D, NORMAL, 1'b0, 0);

        $display("[TB] random transactions");
        for (int i = 0; i < 150; i++) begin
            int b3, sel, modo;
            if ($urandom_range(0, 4) == 0) b3 = int'($urandom_range(0, 255));
            else b3 = int'(($urandom_range(0, 15) << 4)) | ops[$urandom_range(0, 6)];
            sel  = int'($urandom_range(0, 9));
            modo = (sel < 6) ? NORMAL : (sel < 8) ? VENCE : CHOQUE;
            run_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), b3, modo,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
        end

        repeat (5) @(negedge clk);
        checkOutput("pending_tx_start", exp_q.size(), 0);
        checkOutput("pending_error", err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
